// File: rtl/spi_pkg.sv
// Shared types for the SPI master peripheral.
//   reg_idx_e : register index decoded from the bus address
//   state_e   : transfer FSM states
//   control_t : CONTROL register layout
//   status_t  : STATUS register layout (low nibble of the read word)
package spi_pkg;

    localparam int DIV_W = 16;

    typedef enum logic [1:0] {
        REG_CONTROL = 2'd0,
        REG_TX      = 2'd1,
        REG_RX      = 2'd2,
        REG_STATUS  = 2'd3
    } reg_idx_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEAD,
        S_SHIFT,
        S_TRAIL
    } state_e;

    typedef struct packed {
        logic [DIV_W-1:0] divider;
        logic [11:0]      reserved;
        logic             loopback;
        logic             int_en;
        logic             cpha;
        logic             cpol;
    } control_t;

    typedef struct packed {
        logic done;
        logic overrun;
        logic rx_valid;
        logic busy;
    } status_t;

endpackage

// File: rtl/spi_sclk_generator.sv
// Half-period timer and SCLK register for the SPI master.
//   clk_i, rst_i      : system clock, asynchronous active-high reset
//   enable            : transfer in progress; counter held at 0 when low
//   shift             : SCLK may toggle at half-period ends (SHIFT phase)
//   cpol              : idle level of SCLK
//   divider           : half-period = divider+1 clk_i cycles
//   sclk              : serial clock register
//   half_period_tick  : last cycle of the current half-period
//   lead_edge         : tick on which SCLK leaves its idle level
//   trail_edge        : tick on which SCLK returns to its idle level
module spi_sclk_generator
    import spi_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable,
    input  logic             shift,
    input  logic             cpol,
    input  logic [DIV_W-1:0] divider,
    output logic             sclk,
    output logic             half_period_tick,
    output logic             lead_edge,
    output logic             trail_edge
);

    logic [DIV_W-1:0] div_cnt;

    assign half_period_tick = enable && (div_cnt == divider);
    // CPOL cannot change mid-transfer, so the current level tells the edge type.
    assign lead_edge  = half_period_tick && shift && (sclk == cpol);
    assign trail_edge = half_period_tick && shift && (sclk != cpol);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (!enable) begin
            div_cnt <= '0;
            sclk    <= cpol;
        end else begin
            div_cnt <= half_period_tick ? '0 : div_cnt + 1'b1;
            if (half_period_tick && shift)
                sclk <= ~sclk;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Memory-mapped SPI master (one interconnect slave slot).
//   clk_i, rst_i                  : system clock, asynchronous active-high reset
//   write_i/_address_i/_data_i    : write request; write_done_o/write_error_o pulse 1 cycle later
//   read_i/_address_i             : read request; read_data_o + read_done_o 1 cycle later
//   read_error_o                  : tied 0
//   spi_sclk_o/mosi_o/cs_n_o      : SPI pins; spi_miso_i is synchronised by two flops
//   interrupt_o                   : INT_EN & DONE, registered level
// Build option: define SPI_MASTER_LOOPBACK_EN to add CONTROL[3] LOOPBACK
// (sampler takes internal MOSI); otherwise CONTROL[3] reads 0.
module spi_master
    import spi_pkg::*;
#(
    parameter int FRAME_BITS    = 8,
    parameter int DIVIDER_RESET = 49
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        write_i,
    input  logic [1:0]  write_address_i,
    input  logic [31:0] write_data_i,
    output logic        write_done_o,
    output logic        write_error_o,
    input  logic        read_i,
    input  logic [1:0]  read_address_i,
    output logic [31:0] read_data_o,
    output logic        read_done_o,
    output logic        read_error_o,
    output logic        spi_sclk_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i,
    output logic        spi_cs_n_o,
    output logic        interrupt_o
);

    localparam int HW = $clog2(2 * FRAME_BITS);

    state_e                state;
    control_t              ctrl;
    status_t               st;
    logic                  rx_valid, overrun, done;
    logic [FRAME_BITS-1:0] tx_shreg, rx_shreg, rx_reg;
    logic [HW-1:0]         half_cnt;
    logic                  miso_p0, miso_p1, miso_bit;
    logic                  busy, tick, lead_edge, trail_edge;
    logic                  sample, shift_out, complete;
    logic                  wr_err, wr_ok, tx_start;
    reg_idx_e              waddr, raddr;
    logic                  unused_wdata;

    assign waddr        = reg_idx_e'(write_address_i);
    assign raddr        = reg_idx_e'(read_address_i);
    assign busy         = (state != S_IDLE);
    assign read_error_o = 1'b0;
    assign spi_mosi_o   = tx_shreg[FRAME_BITS-1];
    assign unused_wdata = ^write_data_i;

    assign wr_err   = write_i && ((waddr == REG_RX) ||
                                  (busy && (waddr == REG_TX || waddr == REG_CONTROL)));
    assign wr_ok    = write_i && !wr_err;
    assign tx_start = wr_ok && (waddr == REG_TX);
    assign complete = (state == S_TRAIL) && tick;

    // MSB is already on MOSI from LEAD, so CPHA=1 skips the first leading shift.
    assign sample    = ctrl.cpha ? trail_edge : lead_edge;
    assign shift_out = ctrl.cpha ? (lead_edge && half_cnt != '0) : trail_edge;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign miso_bit = ctrl.loopback ? tx_shreg[FRAME_BITS-1] : miso_p1;
`else
    assign miso_bit = miso_p1;
`endif

    assign st = '{done: done, overrun: overrun, rx_valid: rx_valid, busy: busy};

    spi_sclk_generator u_sclk (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .enable           (busy),
        .shift            (state == S_SHIFT),
        .cpol             (ctrl.cpol),
        .divider          (ctrl.divider),
        .sclk             (spi_sclk_o),
        .half_period_tick (tick),
        .lead_edge        (lead_edge),
        .trail_edge       (trail_edge)
    );

    // Transfer FSM
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            spi_cs_n_o <= 1'b1;
            tx_shreg   <= '0;
            half_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tx_start) begin
                        state      <= S_LEAD;
                        spi_cs_n_o <= 1'b0;
                        tx_shreg   <= write_data_i[FRAME_BITS-1:0];
                        half_cnt   <= '0;
                    end
                end
                S_LEAD: begin
                    if (tick)
                        state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (shift_out)
                        tx_shreg <= {tx_shreg[FRAME_BITS-2:0], 1'b0};
                    if (tick) begin
                        half_cnt <= half_cnt + 1'b1;
                        if (half_cnt == HW'(2 * FRAME_BITS - 1))
                            state <= S_TRAIL;
                    end
                end
                S_TRAIL: begin
                    if (tick) begin
                        state      <= S_IDLE;
                        spi_cs_n_o <= 1'b1;
                        tx_shreg   <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // MISO synchroniser and receive shift register
    always_ff @(posedge clk_i) begin
        miso_p0 <= spi_miso_i;
        miso_p1 <= miso_p0;
        if (sample)
            rx_shreg <= {rx_shreg[FRAME_BITS-2:0], miso_bit};
    end

    // Register file and bus responses
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl          <= '{divider: DIV_W'(DIVIDER_RESET), default: '0};
            rx_valid      <= 1'b0;
            overrun       <= 1'b0;
            done          <= 1'b0;
            rx_reg        <= '0;
            read_data_o   <= '0;
            read_done_o   <= 1'b0;
            write_done_o  <= 1'b0;
            write_error_o <= 1'b0;
            interrupt_o   <= 1'b0;
        end else begin
            write_done_o  <= wr_ok;
            write_error_o <= wr_err;
            read_done_o   <= read_i;
            interrupt_o   <= ctrl.int_en & done;

            if (wr_ok && waddr == REG_CONTROL) begin
                ctrl.cpol    <= write_data_i[0];
                ctrl.cpha    <= write_data_i[1];
                ctrl.int_en  <= write_data_i[2];
                ctrl.divider <= write_data_i[31:16];
`ifdef SPI_MASTER_LOOPBACK_EN
                ctrl.loopback <= write_data_i[3];
`endif
            end

            if (wr_ok && waddr == REG_STATUS) begin
                if (write_data_i[1]) rx_valid <= 1'b0;
                if (write_data_i[2]) overrun  <= 1'b0;
                if (write_data_i[3]) done     <= 1'b0;
            end

            if (read_i) begin
                case (raddr)
                    REG_CONTROL: read_data_o <= 32'(ctrl);
                    REG_RX: begin
                        read_data_o <= 32'(rx_reg);
                        rx_valid    <= 1'b0;
                    end
                    REG_STATUS:  read_data_o <= 32'(st);
                    default:     read_data_o <= '0;
                endcase
            end

            // Completion is assigned last so it wins over same-cycle clears.
            if (complete) begin
                rx_reg   <= rx_shreg;
                done     <= 1'b1;
                rx_valid <= 1'b1;
                if (rx_valid)
                    overrun <= 1'b1;
            end
        end
    end

endmodule
